win_checker: RTL and testbench

- Game-logic responder for the Connect Four controller. When logic_go is raised, it reads all 7 board columns from the on/off and player memories through its own address port.
- It then scans for four-in-a-row belonging to the current player and for a full board.
- It returns logic_result to the controller: 0 = UNSURE/busy, 1 = OVER, 2 = NOT OVER.

---
 rtl/win_checker.sv | 146 ++++++++++++++
 tb/tb_win_checker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/win_checker.sv
// win_checker: Connect Four game-logic responder; loads the board one column per cycle,
// then scans for a four-in-a-row owned by the requesting player and for a full board.
module win_checker #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            logic_go,
    input  logic            cur_player,
    input  logic [ROWS-1:0] onoff_data,
    input  logic [ROWS-1:0] player_data,
    output logic [2:0]      mem_address,
    output logic [1:0]      logic_result,
    output logic            is_draw,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                k_q, k_d;
    logic [2:0]                c_q, c_d;
    logic                      pl_q, pl_d;
    logic                      hit_q, hit_d;
    logic [COLS-1:0][ROWS-1:0] onoff_q, onoff_d;
    logic [COLS-1:0][ROWS-1:0] plyr_q, plyr_d;
    logic [1:0]                res_q, res_d;
    logic                      draw_q, draw_d;
    logic                      busy_q, busy_d;

    logic [COLS-1:0][ROWS-1:0] own;
    logic [3:0][ROWS-1:0]      win_col;
    logic                      wide;
    logic                      win_now;
    logic                      full;

    // Window columns past the right edge read as empty, so partial windows never match.
    always_comb begin
        for (int x = 0; x < COLS; x++)
            own[x] = onoff_q[x] & ~(plyr_q[x] ^ {ROWS{pl_q}});
        for (int i = 0; i < 4; i++)
            win_col[i] = (({1'b0, c_q} + 4'(i)) < 4'(COLS)) ? own[c_q + 3'(i)] : '0;
        wide = c_q <= 3'(COLS - 4);
        full = &onoff_q;
        win_now = 1'b0;
        for (int r = 0; r <= ROWS - 4; r++) begin
            win_now |= &win_col[0][r +: 4];
            win_now |= wide & win_col[0][r] & win_col[1][r+1] & win_col[2][r+2] & win_col[3][r+3];
            win_now |= wide & win_col[0][r+3] & win_col[1][r+2] & win_col[2][r+1] & win_col[3][r];
        end
        for (int r = 0; r < ROWS; r++)
            win_now |= wide & win_col[0][r] & win_col[1][r] & win_col[2][r] & win_col[3][r];
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c_d         = c_q;
        pl_d        = pl_q;
        hit_d       = hit_q;
        onoff_d     = onoff_q;
        plyr_d      = plyr_q;
        res_d       = res_q;
        draw_d      = draw_q;
        mem_address = 3'd0;
        case (state_q)
            IDLE: begin
                if (logic_go) begin
                    state_d = LOAD;
                    pl_d    = cur_player;
                    hit_d   = 1'b0;
                    k_d     = 3'd0;
                end
            end
            LOAD: begin
                // Last slot re-presents the final column while its data is captured.
                mem_address = (k_q > 3'(COLS - 1)) ? 3'(COLS - 1) : k_q;
                if (!logic_go) begin
                    state_d = IDLE;
                end else begin
                    if (k_q != 3'd0) begin
                        onoff_d[k_q - 3'd1] = onoff_data;
                        plyr_d[k_q - 3'd1]  = player_data;
                    end
                    k_d = k_q + 3'd1;
                    if (k_q == 3'(COLS)) begin
                        state_d = SCAN;
                        c_d     = 3'd0;
                    end
                end
            end
            SCAN: begin
                if (!logic_go) begin
                    state_d = IDLE;
                end else begin
                    hit_d = hit_q | win_now;
                    c_d   = c_q + 3'd1;
                    if (c_q == 3'(COLS - 1)) begin
                        state_d = DONE;
                        res_d   = (hit_d | full) ? 2'd1 : 2'd2;
                        draw_d  = ~hit_d & full;
                    end
                end
            end
            DONE: begin
                if (!logic_go) begin
                    state_d = IDLE;
                    res_d   = 2'd0;
                    draw_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == SCAN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            c_q     <= '0;
            pl_q    <= 1'b0;
            hit_q   <= 1'b0;
            onoff_q <= '0;
            plyr_q  <= '0;
            res_q   <= 2'd0;
            draw_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            pl_q    <= pl_d;
            hit_q   <= hit_d;
            onoff_q <= onoff_d;
            plyr_q  <= plyr_d;
            res_q   <= res_d;
            draw_q  <= draw_d;
            busy_q  <= busy_d;
        end
    end

    assign logic_result = res_q;
    assign is_draw      = draw_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_win_checker.sv
// tb_win_checker: directed boards against win_checker with a 1-cycle-latency board memory model.
module tb_win_checker;
    logic       clk;
    logic       reset;
    logic       logic_go;
    logic       cur_player;
    logic [5:0] onoff_data;
    logic [5:0] player_data;
    logic [2:0] mem_address;
    logic [1:0] logic_result;
    logic       is_draw;
    logic       busy;

    logic [5:0] mem_on [7];
    logic [5:0] mem_pl [7];
    int n_checks;
    int n_errors;

    win_checker dut (
        .clk(clk),
        .reset(reset),
        .logic_go(logic_go),
        .cur_player(cur_player),
        .onoff_data(onoff_data),
        .player_data(player_data),
        .mem_address(mem_address),
        .logic_result(logic_result),
        .is_draw(is_draw),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        onoff_data  <= mem_on[mem_address];
        player_data <= mem_pl[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_board();
        for (int x = 0; x < 7; x++) begin
            mem_on[x] = 6'h00;
            mem_pl[x] = 6'h00;
        end
    endtask

    task automatic draw_board();
        for (int x = 0; x < 7; x++) begin
            mem_on[x] = 6'h3F;
            mem_pl[x] = (x % 2 == 0) ? 6'h33 : 6'h0C;
        end
    endtask

    task automatic run_req(input logic player, input logic [1:0] exp_res, input logic exp_draw, input string tag);
        int early;
        int busy_n;
        int addr_bad;
        int ea;
        early = 0;
        busy_n = 0;
        addr_bad = 0;
        cur_player = player;
        logic_go = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 1) cur_player = ~player;
            if (i < 16 && logic_result != 2'd0) early++;
            if (busy) busy_n++;
            ea = (i - 1 > 6) ? 6 : i - 1;
            if (i <= 8 && 32'(mem_address) != ea) addr_bad++;
        end
        check({tag, "_early"}, early, 0);
        check({tag, "_busy"}, busy_n, 15);
        check({tag, "_addr"}, addr_bad, 0);
        check({tag, "_res"}, 32'(logic_result), 32'(exp_res));
        check({tag, "_draw"}, 32'(is_draw), 32'(exp_draw));
        @(posedge clk); #1;
        check({tag, "_hold"}, 32'({is_draw, logic_result}), 32'({exp_draw, exp_res}));
        logic_go = 1'b0;
        @(posedge clk); #1;
        check({tag, "_clr"}, 32'({is_draw, logic_result}), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        logic_go = 1'b0;
        cur_player = 1'b0;
        clear_board();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'({busy, is_draw, logic_result, mem_address}), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        clear_board();
        mem_on[3] = 6'h01;
        run_req(1'b0, 2'd2, 1'b0, "single");

        clear_board();
        mem_on[2] = 6'h0F; mem_pl[2] = 6'h0F;
        run_req(1'b1, 2'd1, 1'b0, "vert_p1");
        run_req(1'b0, 2'd2, 1'b0, "vert_p0");

        clear_board();
        for (int x = 3; x < 7; x++) mem_on[x] = 6'h01;
        run_req(1'b0, 2'd1, 1'b0, "horiz_p0");
        run_req(1'b1, 2'd2, 1'b0, "horiz_opp");

        clear_board();
        mem_on[0] = 6'h01; mem_pl[0] = 6'h01;
        mem_on[1] = 6'h02; mem_pl[1] = 6'h02;
        mem_on[2] = 6'h04; mem_pl[2] = 6'h04;
        mem_on[3] = 6'h08; mem_pl[3] = 6'h08;
        run_req(1'b1, 2'd1, 1'b0, "updiag");

        clear_board();
        mem_on[3] = 6'h20; mem_on[4] = 6'h10; mem_on[5] = 6'h08; mem_on[6] = 6'h04;
        run_req(1'b0, 2'd1, 1'b0, "dndiag");

        draw_board();
        run_req(1'b1, 2'd1, 1'b1, "draw");
        mem_on[6] = 6'h1F;
        run_req(1'b1, 2'd2, 1'b0, "almost_full");
        draw_board();
        mem_pl[0] = 6'h0F;
        run_req(1'b1, 2'd1, 1'b0, "full_win");

        // Abort in LOAD at k=4, then restart two cycles later.
        clear_board();
        mem_on[2] = 6'h0F; mem_pl[2] = 6'h0F;
        cur_player = 1'b1;
        logic_go = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_k4_addr", 32'(mem_address), 4);
        logic_go = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'({busy, logic_result, mem_address}), 0);
        @(posedge clk); #1;
        run_req(1'b1, 2'd1, 1'b0, "restart");

        // Abort in SCAN after the hit is found; the next request must not inherit it.
        cur_player = 1'b1;
        logic_go = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        logic_go = 1'b0;
        @(posedge clk); #1;
        check("abort_scan", 32'({busy, logic_result}), 0);
        clear_board();
        mem_on[3] = 6'h01;
        run_req(1'b1, 2'd2, 1'b0, "no_stale");

        // Reset during SCAN c=3.
        clear_board();
        mem_on[2] = 6'h0F; mem_pl[2] = 6'h0F;
        cur_player = 1'b1;
        logic_go = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_scan", 32'({busy, is_draw, logic_result, mem_address}), 0);
        logic_go = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset while holding a result in DONE.
        logic_go = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("done_res", 32'(logic_result), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_done", 32'({busy, is_draw, logic_result}), 0);
        logic_go = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        run_req(1'b1, 2'd1, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
